axist_rand_chk: RTL



---
 rtl/axist_rand_chk.sv | 114 +++++++++++
 1 files changed

// File: rtl/axist_rand_chk.sv
// axist_rand_chk: receive-side LFSR pattern checker for the AXI4-ST test path.
// Regenerates the generator's pseudo-random sequence from a seed and compares
// every accepted beat against it.
//
// Build option: define AXIST_CHK_RESYNC_EN to re-lock the expected sequence to
// the received data after a mismatching beat.
//
// Parameters:
//   LEADER_MODE     1 = FULL (40-bit data), 2 = HALF (80-bit data)
// Ports:
//   clk             block clock, rising edge
//   rst             synchronous active-high reset
//   chk_start       one-cycle arm pulse (honoured in IDLE and DONE)
//   seed_in         expected first beat, sampled on chk_start
//   exp_beats       number of beats to check, sampled on chk_start
//   s_tvalid/s_tready/s_tdata  AXI-ST sink
//   busy, done, pass           status (pass valid while done)
//   beat_cnt, err_cnt, first_err_beat  result counters
module axist_rand_chk #(
   parameter int unsigned LEADER_MODE = 1,
   localparam int unsigned W = LEADER_MODE * 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         chk_start,
   input  logic [W-1:0] seed_in,
   input  logic [15:0]  exp_beats,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic [W-1:0] s_tdata,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [15:0]  beat_cnt,
   output logic [15:0]  err_cnt,
   output logic [15:0]  first_err_beat
);

   // Feedback taps; the top tap is always the MSB.
   localparam int unsigned TapB = (LEADER_MODE == 1) ? 37 : 78;
   localparam int unsigned TapC = (LEADER_MODE == 1) ? 20 : 42;
   localparam int unsigned TapD = (LEADER_MODE == 1) ? 18 : 41;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q;
   logic [W-1:0]   exp_q;
   logic [15:0]    beats_q;

   logic           accept;
   logic           mismatch;
   logic [15:0]    beat_nxt;
   logic [W-1:0]   exp_adv;

   function automatic logic [W-1:0] step(input logic [W-1:0] x);
      return {x[W-2:0], x[W-1] ^ x[TapB] ^ x[TapC] ^ x[TapD]};
   endfunction

   always_comb begin
      accept   = (state_q == StRun) && s_tvalid;
      mismatch = (s_tdata != exp_q);
      beat_nxt = beat_cnt + 16'd1;
`ifdef AXIST_CHK_RESYNC_EN
      exp_adv  = mismatch ? step(s_tdata) : step(exp_q);
`else
      exp_adv  = step(exp_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         exp_q          <= '0;
         beats_q        <= '0;
         beat_cnt       <= '0;
         err_cnt        <= '0;
         first_err_beat <= 16'hFFFF;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (chk_start) begin
                  exp_q          <= seed_in;
                  beats_q        <= exp_beats;
                  beat_cnt       <= '0;
                  err_cnt        <= '0;
                  first_err_beat <= 16'hFFFF;
                  state_q        <= (exp_beats == 16'd0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (accept) begin
                  if (mismatch) begin
                     if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                     if (first_err_beat == 16'hFFFF) first_err_beat <= beat_cnt;
                  end
                  exp_q    <= exp_adv;
                  beat_cnt <= beat_nxt;
                  if (beat_nxt == beats_q) state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Status outputs decode the registered state only.
   always_comb begin
      s_tready = (state_q == StRun);
      busy     = (state_q == StRun);
      done     = (state_q == StDone);
      pass     = (state_q == StDone) && (err_cnt == 16'd0);
   end

endmodule
